// File: rtl/grant_seq_pkg.sv
// Shared types and helpers for the grant sequencer: FSM state encoding,
// default port count and a one-hot to binary index converter.
package grant_seq_pkg;

  localparam int DEF_PORTS = 4;
  localparam int MAX_PORTS = 32;
  localparam int IDX_W     = $clog2(DEF_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // OR-reduce the indices of set bits; exact for a one-hot or zero input
  function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      r = r | (oh[i] ? unsigned'(i) : 32'd0);
    end
    return r;
  endfunction

endpackage

// File: rtl/grant_sequencer_rr_pick.sv
// Combinational winner picker: first eligible index strictly after a base index,
// wrapping. Fixed priority is the same search with the base forced to N-1.
module rr_pick
  import grant_seq_pkg::*;
#(
  parameter int N_PORTS = DEF_PORTS,
  parameter int IW      = IDX_W
) (
  input  logic [N_PORTS-1:0] eligible,
  input  logic [IW-1:0]      last_idx,
  input  logic               rr_mode,
  output logic [N_PORTS-1:0] winner,
  output logic [IW-1:0]      winner_idx,
  output logic               any
);

  // Rotating scan; each position is visited exactly once so winner[pos] is written once
  always_comb begin
    int                   base;
    int                   pos;
    logic                 hit;
    logic [MAX_PORTS-1:0] wide;
    winner = '0;
    any    = 1'b0;
    base   = rr_mode ? int'(last_idx) : (N_PORTS - 1);
    for (int off = 1; off <= N_PORTS; off++) begin
      pos         = (base + off) % N_PORTS;
      hit         = !any && eligible[pos];
      winner[pos] = hit;
      any         = any | hit;
    end
    wide                = '0;
    wide[N_PORTS-1:0]   = winner;
    winner_idx          = IW'(onehot_to_idx(wide));
  end

endmodule

// File: rtl/grant_sequencer.sv
// Once-per-round request sequencer: every requester present at arbitration time
// gets one registered one-hot grant, held until ack or timeout.
module grant_sequencer
  import grant_seq_pkg::*;
#(
  parameter int N_PORTS     = DEF_PORTS,
  parameter int RR_MODE     = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_PORTS-1:0]         req,
  input  logic                       ack,
  output logic [N_PORTS-1:0]         grant,
  output logic [$clog2(N_PORTS)-1:0] grant_idx,
  output logic                       busy,
  output logic                       done,
  output logic [N_PORTS-1:0]         served,
  output logic                       timeout_err
);

  localparam int   IW      = $clog2(N_PORTS);
  localparam int   TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int   TO_LAST = (ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0;
  localparam logic TO_EN   = (ACK_TIMEOUT > 0);

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]      grant_idx_q, grant_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N_PORTS-1:0] served_q, served_d;
  logic               timeout_err_q, timeout_err_d;
  logic [N_PORTS-1:0] tag_q, tag_d;
  logic [IW-1:0]      last_idx_q, last_idx_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic [N_PORTS-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               timeout_hit;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_pick (
    .eligible   (req & tag_q),
    .last_idx   (last_idx_q),
    .rr_mode    (RR_MODE != 0),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  assign timeout_hit = TO_EN && (timer_q == TW'(TO_LAST));

  // Round sequencing: tag marks ports still owed a grant this round
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    busy_d        = busy_q;
    done_d        = done_q;
    served_d      = served_q;
    timeout_err_d = timeout_err_q;
    tag_d         = tag_q;
    last_idx_d    = last_idx_q;
    timer_d       = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tag_d         = '1;
          served_d      = '0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (pick_any) begin
          grant_d     = pick_oh;
          grant_idx_d = pick_idx;
          timer_d     = '0;
          state_d     = GRANT;
        end else begin
          grant_d = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      GRANT: begin
        if (ack) begin
          tag_d[grant_idx_q]    = 1'b0;
          served_d[grant_idx_q] = 1'b1;
          last_idx_d            = grant_idx_q;
          grant_d               = '0;
          state_d               = ARB;
        end else if (timeout_hit) begin
          tag_d[grant_idx_q] = 1'b0;
          timeout_err_d      = 1'b1;
          last_idx_d         = grant_idx_q;
          grant_d            = '0;
          state_d            = ARB;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears grant asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      served_q      <= '0;
      timeout_err_q <= 1'b0;
      tag_q         <= '1;
      last_idx_q    <= IW'(N_PORTS - 1);
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      served_q      <= served_d;
      timeout_err_q <= timeout_err_d;
      tag_q         <= tag_d;
      last_idx_q    <= last_idx_d;
      timer_q       <= timer_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign served      = served_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_grant_sequencer.sv
// Bench for grant_sequencer: a fixed-priority (timeout 3) and a round-robin
// instance share stimulus; a table of rounds feeds an expected-grant queue.
module tb_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;
  logic       use_rr = 1'b0;

  logic [3:0] grant_fp, grant_rr, served_fp, served_rr;
  logic [1:0] idx_fp, idx_rr;
  logic       busy_fp, busy_rr, done_fp, done_rr, terr_fp, terr_rr;

  logic [3:0] g, d_served;
  logic [1:0] gidx;
  logic       d_busy, d_done, d_terr;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  typedef struct packed {
    logic        do_reset;
    logic        rr;
    logic [3:0]  req;
    logic [3:0]  req_after;
    logic [3:0]  noack;
    int          n;
    logic [15:0] exp_seq;
    logic [3:0]  served;
    logic        terr;
  } vec_t;

  vec_t vecs[10];

  grant_sequencer #(.N_PORTS(4), .RR_MODE(0), .ACK_TIMEOUT(3)) dut_fp (
    .clk(clk), .rst(rst), .start(start), .req(req), .ack(ack),
    .grant(grant_fp), .grant_idx(idx_fp), .busy(busy_fp), .done(done_fp),
    .served(served_fp), .timeout_err(terr_fp)
  );

  grant_sequencer #(.N_PORTS(4), .RR_MODE(1), .ACK_TIMEOUT(15)) dut_rr (
    .clk(clk), .rst(rst), .start(start), .req(req), .ack(ack),
    .grant(grant_rr), .grant_idx(idx_rr), .busy(busy_rr), .done(done_rr),
    .served(served_rr), .timeout_err(terr_rr)
  );

  assign g        = use_rr ? grant_rr  : grant_fp;
  assign gidx     = use_rr ? idx_rr    : idx_fp;
  assign d_busy   = use_rr ? busy_rr   : busy_fp;
  assign d_done   = use_rr ? done_rr   : done_fp;
  assign d_served = use_rr ? served_rr : served_fp;
  assign d_terr   = use_rr ? terr_rr   : terr_fp;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_round(input int v);
    vec_t       t;
    logic [3:0] prev, cur, e;
    int         held;
    int         eidx;
    bit         seen_first, got_done;
    t      = vecs[v];
    use_rr = t.rr;
    if (t.do_reset) apply_reset();
    for (int i = 0; i < t.n; i++) exp_q.push_back(t.exp_seq[i*4 +: 4]);
    @(negedge clk);
    req   = t.req;
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    prev       = 4'b0000;
    held       = 0;
    seen_first = 1'b0;
    got_done   = 1'b0;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      ack = 1'b0;
      cur = g;
      if (d_done) begin
        got_done = 1'b1;
        chk("busy_at_done", {31'd0, d_busy}, 32'd1);
        chk("served", {28'd0, d_served}, {28'd0, t.served});
        chk("timeout_err", {31'd0, d_terr}, {31'd0, t.terr});
      end else if (cur != 4'b0000) begin
        if (prev == 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("grant_extra", {28'd0, cur}, 32'd0);
          end else begin
            e    = exp_q.pop_front();
            eidx = 0;
            for (int b = 0; b < 4; b++) if (e[b]) eidx = b;
            chk("grant", {28'd0, cur}, {28'd0, e});
            chk("grant_idx", {30'd0, gidx}, eidx);
          end
          held = 0;
          if (!seen_first) begin
            seen_first = 1'b1;
            req        = t.req_after;
          end
        end
        held++;
        if ((cur & t.noack) == 4'b0000) ack = 1'b1;
      end else if ((prev & t.noack) != 4'b0000) begin
        chk("timeout_hold", held, 32'd3);
      end
      prev = cur;
      @(negedge clk);
    end
    if (!got_done) chk("done_reached", 32'd0, 32'd1);
    chk("done_pulse_width", {31'd0, d_done}, 32'd0);
    chk("busy_after_done", {31'd0, d_busy}, 32'd0);
    chk("grants_missing", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit reached;
    // rst, rr, req, req_after, noack, n, seq (first grant in low nibble), served, terr
    vecs[0] = '{1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0000, 2, 16'h0082, 4'b1010, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4, 16'h8421, 4'b1111, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4, 16'h8421, 4'b1111, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 2, 16'h0021, 4'b0011, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4, 16'h2184, 4'b1111, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'b0101, 4'b0101, 4'b0001, 2, 16'h0041, 4'b0100, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 16'h0000, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'b0001, 4'b0101, 4'b0000, 2, 16'h0041, 4'b0101, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 4'b0111, 4'b0011, 4'b0000, 2, 16'h0021, 4'b0011, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 4'b0111, 4'b0111, 4'b0000, 3, 16'h0421, 4'b0111, 1'b0};

    rst = 1'b0;
    #12;
    chk("rst_grant", {28'd0, grant_fp}, 32'd0);
    chk("rst_idx", {30'd0, idx_fp}, 32'd0);
    chk("rst_busy", {31'd0, busy_fp}, 32'd0);
    chk("rst_done", {31'd0, done_fp}, 32'd0);
    chk("rst_served", {28'd0, served_fp}, 32'd0);
    chk("rst_terr", {31'd0, terr_fp}, 32'd0);

    for (int v = 0; v < 9; v++) run_round(v);

    // Reset pulled while a grant is held must drop it without a clock edge
    apply_reset();
    use_rr = 1'b0;
    @(negedge clk);
    req   = 4'b0100;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 10 && !reached; cyc++) begin
      if (g == 4'b0100) reached = 1'b1;
      else @(negedge clk);
    end
    chk("mid_grant_reached", {31'd0, reached}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_grant_drop", {28'd0, grant_fp}, 32'd0);
    chk("async_busy_drop", {31'd0, busy_fp}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_round(9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
